// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered RV32 instruction decoder with valid/ready handshake and flush.
// Define RISCV_DECODE_PERF_CNT_EN to add saturating inst_cnt/illegal_cnt performance counters.
module riscv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
`ifdef RISCV_DECODE_PERF_CNT_EN
  output logic [6:0]       funct7,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`else
  output logic [6:0]       funct7
`endif
);
  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;
  logic              r_valid, r_illegal;
  logic [6:0]        r_opcode, r_funct7;
  logic [4:0]        r_rd, r_rs1, r_rs2;
  logic [2:0]        r_funct3, r_fmt;
  logic [XLEN-1:0]   r_imm;
  logic              w_acc, w_illegal;
  logic [6:0]        w_op;
  logic [2:0]        w_fmt;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm;
  assign w_op = inst[6:0];
  assign in_ready = !rst && !flush && (!r_valid || out_ready);
  assign w_acc = in_valid && in_ready;
  always_comb begin
    w_fmt = (w_op == 7'h37 || w_op == 7'h17) ? FMT_U :
            (w_op == 7'h6f) ? FMT_J :
            (w_op inside {7'h67, 7'h03, 7'h13, 7'h0f, 7'h73}) ? FMT_I :
            (w_op == 7'h63) ? FMT_B :
            (w_op == 7'h23) ? FMT_S :
            (w_op == 7'h33) ? FMT_R : FMT_X;
    w_illegal = (w_fmt == FMT_X);
    w_imm32 = (w_fmt == FMT_I) ? {{20{inst[31]}}, inst[31:20]} :
              (w_fmt == FMT_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
              (w_fmt == FMT_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
              (w_fmt == FMT_U) ? {inst[31:12], 12'b0} :
              (w_fmt == FMT_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
              32'sd0;
  end
  // signed size cast replicates inst[31] up to XLEN
  assign w_imm = XLEN'(w_imm32);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_opcode  <= '0;
      r_funct7  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_fmt     <= FMT_X;
      r_imm     <= '0;
    end else begin
      r_valid <= flush ? 1'b0 : w_acc ? 1'b1 : out_ready ? 1'b0 : r_valid;
      if (w_acc) begin
        r_illegal <= w_illegal;
        r_opcode  <= w_op;
        r_funct7  <= inst[31:25];
        r_rd      <= inst[11:7];
        r_rs1     <= inst[19:15];
        r_rs2     <= inst[24:20];
        r_funct3  <= inst[14:12];
        r_fmt     <= w_fmt;
        r_imm     <= w_imm;
      end
    end
  end
  assign out_valid = r_valid;
  assign opcode    = r_opcode;
  assign rd        = r_rd;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign funct3    = r_funct3;
  assign funct7    = r_funct7;
  assign imm       = r_imm;
  assign fmt       = r_fmt;
  assign illegal   = r_illegal;
`ifdef RISCV_DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] r_inst_cnt, r_illegal_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_cnt    <= '0;
      r_illegal_cnt <= '0;
    end else if (w_acc) begin
      if (~&r_inst_cnt) r_inst_cnt <= r_inst_cnt + 1'b1;
      if (w_illegal && ~&r_illegal_cnt) r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end
  assign inst_cnt    = r_inst_cnt;
  assign illegal_cnt = r_illegal_cnt;
`endif
endmodule
